// File: rtl/fsm_state_checker.sv
// fsm_state_checker: passive monitor for the 0->1->2->3->0 controller state cycle.
// Locks on state 0, counts 3->0 wraps, flags illegal jumps and stalls with capture.
module fsm_state_checker #(
  parameter int unsigned STALL_MAX = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       state_in,
  input  logic             enable,
  input  logic             clear,
  output logic             locked,
  output logic             err_illegal,
  output logic             err_stall,
  output logic [1:0]       bad_from,
  output logic [1:0]       bad_to,
  output logic [CNT_W-1:0] wrap_count
);

  localparam int unsigned RUN_W = 8;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKED   = 2'd1,
    ST_ERROR    = 2'd2
  } fsm_t;

  fsm_t             r_fsm,         w_fsm;
  logic [1:0]       r_prev,        w_prev;
  logic [RUN_W-1:0] r_run_len,     w_run_len;
  logic             r_locked,      w_locked;
  logic             r_err_illegal, w_err_illegal;
  logic             r_err_stall,   w_err_stall;
  logic [1:0]       r_bad_from,    w_bad_from;
  logic [1:0]       r_bad_to,      w_bad_to;
  logic [CNT_W-1:0] r_wrap_count,  w_wrap_count;

  // One extra bit so a run at the top of the range cannot alias back to a small value
  logic [RUN_W:0]   w_run_inc;
  logic [1:0]       w_step;

  assign w_run_inc = {1'b0, r_run_len} + (RUN_W+1)'(1);
  assign w_step    = r_prev + 2'd1;

  // State register with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fsm         <= ST_UNLOCKED;
      r_prev        <= 2'd0;
      r_run_len     <= '0;
      r_locked      <= 1'b0;
      r_err_illegal <= 1'b0;
      r_err_stall   <= 1'b0;
      r_bad_from    <= 2'd0;
      r_bad_to      <= 2'd0;
      r_wrap_count  <= '0;
    end else begin
      r_fsm         <= w_fsm;
      r_prev        <= w_prev;
      r_run_len     <= w_run_len;
      r_locked      <= w_locked;
      r_err_illegal <= w_err_illegal;
      r_err_stall   <= w_err_stall;
      r_bad_from    <= w_bad_from;
      r_bad_to      <= w_bad_to;
      r_wrap_count  <= w_wrap_count;
    end
  end

  // Next-state and checking logic; clear overrides enable and any error this cycle
  always_comb begin
    w_fsm         = r_fsm;
    w_prev        = r_prev;
    w_run_len     = r_run_len;
    w_err_illegal = r_err_illegal;
    w_err_stall   = r_err_stall;
    w_bad_from    = r_bad_from;
    w_bad_to      = r_bad_to;
    w_wrap_count  = r_wrap_count;

    if (clear) begin
      w_fsm         = ST_UNLOCKED;
      w_prev        = 2'd0;
      w_run_len     = '0;
      w_err_illegal = 1'b0;
      w_err_stall   = 1'b0;
      w_bad_from    = 2'd0;
      w_bad_to      = 2'd0;
      w_wrap_count  = '0;
    end else if (enable) begin
      case (r_fsm)
        ST_UNLOCKED: begin
          if (state_in == 2'd0) begin
            w_fsm     = ST_LOCKED;
            w_prev    = 2'd0;
            w_run_len = RUN_W'(1);
          end
        end
        ST_LOCKED: begin
          w_prev = state_in;
          if (state_in == r_prev) begin
            w_run_len = w_run_inc[RUN_W-1:0];
            if (w_run_inc > (RUN_W+1)'(STALL_MAX)) begin
              w_err_stall = 1'b1;
              w_bad_from  = r_prev;
              w_bad_to    = state_in;
              w_fsm       = ST_ERROR;
            end
          end else if (state_in == w_step) begin
            w_run_len = RUN_W'(1);
            if (r_prev == 2'd3 && r_wrap_count != {CNT_W{1'b1}}) begin
              w_wrap_count = r_wrap_count + CNT_W'(1);
            end
          end else begin
            w_err_illegal = 1'b1;
            w_bad_from    = r_prev;
            w_bad_to      = state_in;
            w_fsm         = ST_ERROR;
          end
        end
        ST_ERROR: begin
          w_fsm = ST_ERROR;
        end
        default: begin
          w_fsm = ST_UNLOCKED;
        end
      endcase
    end

    w_locked = (w_fsm == ST_LOCKED);
  end

  assign locked      = r_locked;
  assign err_illegal = r_err_illegal;
  assign err_stall   = r_err_stall;
  assign bad_from    = r_bad_from;
  assign bad_to      = r_bad_to;
  assign wrap_count  = r_wrap_count;

endmodule

// File: tb/tb_fsm_state_checker.sv
// Directed, table-driven bench for fsm_state_checker (STALL_MAX = 4, CNT_W = 16).
module tb_fsm_state_checker;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned OUT_W = 7 + CNT_W;

  logic             clk;
  logic             reset;
  logic [1:0]       state_in;
  logic             enable;
  logic             clear;
  logic             locked;
  logic             err_illegal;
  logic             err_stall;
  logic [1:0]       bad_from;
  logic [1:0]       bad_to;
  logic [CNT_W-1:0] wrap_count;

  typedef struct {
    logic             en;
    logic             clr;
    logic [1:0]       st;
    logic             lk;
    logic             ill;
    logic             stl;
    logic [1:0]       fr;
    logic [1:0]       to;
    logic [CNT_W-1:0] wr;
  } vec_t;

  vec_t vecs[$];
  int   n_tests;
  int   n_fail;

  fsm_state_checker #(.STALL_MAX(4), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .state_in   (state_in),
    .enable     (enable),
    .clear      (clear),
    .locked     (locked),
    .err_illegal(err_illegal),
    .err_stall  (err_stall),
    .bad_from   (bad_from),
    .bad_to     (bad_to),
    .wrap_count (wrap_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input logic en, input logic clr, input logic [1:0] st,
                              input logic lk, input logic ill, input logic stl,
                              input logic [1:0] fr, input logic [1:0] to, input int wr);
    vec_t v;
    v.en = en; v.clr = clr; v.st = st;
    v.lk = lk; v.ill = ill; v.stl = stl; v.fr = fr; v.to = to; v.wr = CNT_W'(wr);
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic lk, input logic ill, input logic stl,
                       input logic [1:0] fr, input logic [1:0] to, input logic [CNT_W-1:0] wr);
    logic [OUT_W-1:0] got;
    logic [OUT_W-1:0] exp;
    got = {locked, err_illegal, err_stall, bad_from, bad_to, wrap_count};
    exp = {lk, ill, stl, fr, to, wr};
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got lk=%b ill=%b stl=%b from=%0d to=%0d wrap=%0d, want lk=%b ill=%b stl=%b from=%0d to=%0d wrap=%0d",
               name, locked, err_illegal, err_stall, bad_from, bad_to, wrap_count,
               lk, ill, stl, fr, to, wr);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge
  task automatic step(input logic en, input logic clr, input logic [1:0] st);
    @(negedge clk);
    enable   = en;
    clear    = clr;
    state_in = st;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    reset    = 1'b0;
    enable   = 1'b0;
    clear    = 1'b0;
    state_in = 2'd0;

    // Clean run: 3 full cycles plus a final 0
    for (int c = 0; c < 13; c++) add(1, 0, 2'(c % 4), 1, 0, 0, 0, 0, c / 4);
    // Illegal jump 1 -> 3, then ERROR ignores a full cycle
    add(1, 0, 1, 1, 0, 0, 0, 0, 3);
    add(1, 0, 3, 0, 1, 0, 1, 3, 3);
    add(1, 0, 0, 0, 1, 0, 1, 3, 3);
    add(1, 0, 1, 0, 1, 0, 1, 3, 3);
    add(1, 0, 2, 0, 1, 0, 1, 3, 3);
    add(1, 0, 3, 0, 1, 0, 1, 3, 3);
    add(1, 0, 0, 0, 1, 0, 1, 3, 3);
    // Clear with enable low still clears
    add(0, 1, 0, 0, 0, 0, 0, 0, 0);
    // Relock, then 4 samples of 2 followed by 3: no error
    add(1, 0, 0, 1, 0, 0, 0, 0, 0);
    add(1, 0, 1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(1, 0, 2, 1, 0, 0, 0, 0, 0);
    add(1, 0, 3, 1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 0, 0, 0, 0, 1);
    add(1, 0, 1, 1, 0, 0, 0, 0, 1);
    // 5 samples of 2: stall on the fifth
    for (int i = 0; i < 4; i++) add(1, 0, 2, 1, 0, 0, 0, 0, 1);
    add(1, 0, 2, 0, 0, 1, 2, 2, 1);
    add(1, 0, 3, 0, 0, 1, 2, 2, 1);
    // Clear beats a same-cycle sample of 0; next 0 relocks
    add(1, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 0, 0, 0, 0, 0);
    // Enable gating: 2 enabled 1s, 10 disabled 1s, then an enabled 2
    add(1, 0, 1, 1, 0, 0, 0, 0, 0);
    add(1, 0, 1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) add(0, 0, 1, 1, 0, 0, 0, 0, 0);
    add(1, 0, 2, 1, 0, 0, 0, 0, 0);
    add(1, 0, 3, 1, 0, 0, 0, 0, 0);
    // Bring wrap_count to 2 ahead of the async reset
    add(1, 0, 0, 1, 0, 0, 0, 0, 1);
    add(1, 0, 1, 1, 0, 0, 0, 0, 1);
    add(1, 0, 2, 1, 0, 0, 0, 0, 1);
    add(1, 0, 3, 1, 0, 0, 0, 0, 1);
    add(1, 0, 0, 1, 0, 0, 0, 0, 2);

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("reset_values", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].clr, vecs[i].st);
      check($sformatf("vec%0d", i), vecs[i].lk, vecs[i].ill, vecs[i].stl,
            vecs[i].fr, vecs[i].to, vecs[i].wr);
    end

    // Async reset between edges while wrap_count = 2
    @(negedge clk);
    enable   = 1'b1;
    state_in = 2'd1;
    #2;
    reset = 1'b0;
    #1;
    check("async_reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    // Relock needs a fresh 0
    step(1, 0, 1);
    check("post_reset_1", 0, 0, 0, 0, 0, 0);
    step(1, 0, 2);
    check("post_reset_2", 0, 0, 0, 0, 0, 0);
    step(1, 0, 0);
    check("post_reset_relock", 1, 0, 0, 0, 0, 0);
    step(1, 0, 1);
    check("post_reset_step", 1, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
